// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with multi-cycle grant lock; owner releases on done, request drop,
// or (when RR_HOLD_ARB_TIMEOUT_EN is defined) after MAX_HOLD grant cycles.
module rr_hold_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_i,
  input  logic [N-1:0]         done_i,
  output logic [N-1:0]         gnt_o,
  output logic                 gnt_valid_o,
  output logic [$clog2(N)-1:0] gnt_id_o,
  output logic                 timeout_o
);

  localparam int ID_W = $clog2(N);

  if (N < 2 || N > 16) begin : g_bad_n
    $error("rr_hold_arbiter: N must be in 2..16");
  end
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
    $error("rr_hold_arbiter: MAX_HOLD must be in 2..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] next_ptr;
  logic            found;
  logic            owner_release;
  logic            release_evt;
  logic [N-1:0]    gnt_d;
  logic            gnt_valid_d;
  logic [ID_W-1:0] gnt_id_d;

`ifdef RR_HOLD_ARB_TIMEOUT_EN
  localparam int              HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              hold_limit;
  logic              timeout_d;

  assign hold_limit = (hold_q == HOLD_LAST);
`endif

  // Wrapping scan starting at ptr; the index is folded manually so N need not be a power of 2.
  always_comb begin
    int idx;
    // NOTE: every variable assigned in a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[ID_W'(idx)]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Only the owner's done/req bits matter; gnt_o is one-hot so masking selects them.
  assign owner_release = (|(done_i & gnt_o)) | ~(|(req_i & gnt_o));
  assign next_ptr      = (gnt_id_o == ID_W'(N - 1)) ? '0 : gnt_id_o + ID_W'(1);

`ifdef RR_HOLD_ARB_TIMEOUT_EN
  assign release_evt = owner_release | hold_limit;
`else
  assign release_evt = owner_release;
`endif

  // State register: FSM state, pointer, hold counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_o       <= '0;
      gnt_valid_o <= 1'b0;
      gnt_id_o    <= '0;
`ifdef RR_HOLD_ARB_TIMEOUT_EN
      hold_q      <= '0;
      timeout_o   <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples the
      // pre-edge values regardless of statement order.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_o       <= gnt_d;
      gnt_valid_o <= gnt_valid_d;
      gnt_id_o    <= gnt_id_d;
`ifdef RR_HOLD_ARB_TIMEOUT_EN
      hold_q      <= hold_d;
      timeout_o   <= timeout_d;
`endif
    end
  end

`ifndef RR_HOLD_ARB_TIMEOUT_EN
  assign timeout_o = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found)       state_d = GRANT;
      GRANT:   if (release_evt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, pointer and hold counter.
  always_comb begin
    gnt_d       = gnt_o;
    gnt_valid_d = gnt_valid_o;
    gnt_id_d    = gnt_id_o;
    ptr_d       = ptr_q;
`ifdef RR_HOLD_ARB_TIMEOUT_EN
    hold_d      = hold_q;
    timeout_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
`ifdef RR_HOLD_ARB_TIMEOUT_EN
        hold_d      = '0;
`endif
        if (found) begin
          gnt_d       = N'(1) << winner;
          gnt_valid_d = 1'b1;
          gnt_id_d    = winner;
        end
      end
      GRANT: begin
        if (release_evt) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_id_d    = '0;
          ptr_d       = next_ptr;
`ifdef RR_HOLD_ARB_TIMEOUT_EN
          // A done or request drop coinciding with the limit is an ordinary release.
          timeout_d   = hold_limit & ~owner_release;
          hold_d      = '0;
`endif
        end else begin
`ifdef RR_HOLD_ARB_TIMEOUT_EN
          hold_d = hold_limit ? hold_q : hold_q + HOLD_W'(1);
`endif
        end
      end
      default: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed self-checking bench for rr_hold_arbiter (N=4, MAX_HOLD=8); covers both
// builds of RR_HOLD_ARB_TIMEOUT_EN.
module tb_rr_hold_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_i;
  logic [3:0] done_i;
  logic [3:0] gnt_o;
  logic       gnt_valid_o;
  logic [1:0] gnt_id_o;
  logic       timeout_o;

  int n_checks = 0;
  int n_fails  = 0;

  rr_hold_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req_i),
    .done_i     (done_i),
    .gnt_o      (gnt_o),
    .gnt_valid_o(gnt_valid_o),
    .gnt_id_o   (gnt_id_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks all outputs; gnt_valid_o is expected to be the OR of the expected grant.
  task automatic chk(input string tag, input logic [3:0] g, input logic [1:0] id,
                     input logic to);
    check({tag, "_gnt"},   32'(gnt_o),       32'(g));
    check({tag, "_valid"}, 32'(gnt_valid_o), 32'(|g));
    check({tag, "_id"},    32'(gnt_id_o),    32'(id));
    check({tag, "_tmo"},   32'(timeout_o),   32'(to));
  endtask

  initial begin
    logic [1:0] order [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    // Reset, then idle with no requests.
    reset  = 1'b1;
    req_i  = 4'b0000;
    done_i = 4'b0000;
    tick();
    tick();
    chk("reset", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("idle%0d", i), 4'b0000, 2'd0, 1'b0);
    end

    // req 1010 from ptr 0: owner 1 for cycles 1..3, done at 3, then owner 3 at cycle 5.
    req_i = 4'b1010;
    tick(); chk("rr_c1", 4'b0010, 2'd1, 1'b0);
    tick(); chk("rr_c2", 4'b0010, 2'd1, 1'b0);
    tick(); chk("rr_c3", 4'b0010, 2'd1, 1'b0);
    done_i = 4'b0010;
    tick(); chk("rr_c4", 4'b0000, 2'd0, 1'b0);
    done_i = 4'b0000;
    tick(); chk("rr_c5", 4'b1000, 2'd3, 1'b0);
    req_i = 4'b0000;
    tick(); chk("rr_c6", 4'b0000, 2'd0, 1'b0);   // pointer wraps 3 -> 0

    // All four requesting; each owner releases after two grant cycles.
    req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << order[g];
      tick(); chk($sformatf("all_g%0d_a", g), exp_g, order[g], 1'b0);
      tick(); chk($sformatf("all_g%0d_b", g), exp_g, order[g], 1'b0);
      done_i = exp_g;
      tick(); chk($sformatf("all_g%0d_idle", g), 4'b0000, 2'd0, 1'b0);
      done_i = 4'b0000;
      if (g == 4) req_i = 4'b0000;
    end

    // Hold limit with pointer at 1: requester 2 wins.
    req_i = 4'b0100;
`ifdef RR_HOLD_ARB_TIMEOUT_EN
    for (int i = 0; i < MAX_HOLD; i++) begin
      tick(); chk($sformatf("tmo_hold%0d", i), 4'b0100, 2'd2, 1'b0);
    end
    tick(); chk("tmo_pulse", 4'b0000, 2'd0, 1'b1);
    tick(); chk("tmo_regrant", 4'b0100, 2'd2, 1'b0);
`else
    for (int i = 0; i < MAX_HOLD + 4; i++) begin
      tick(); chk($sformatf("notmo_hold%0d", i), 4'b0100, 2'd2, 1'b0);
    end
`endif
    done_i = 4'b0100;
    tick(); chk("tmo_done_rel", 4'b0000, 2'd0, 1'b0);
    done_i = 4'b0000;
    req_i  = 4'b0001;                            // ptr is 3: scan 3,0 picks 0

    // Owner 0 drops its request on the 8th grant cycle: normal release, no timeout.
    for (int i = 0; i < MAX_HOLD; i++) begin
      tick(); chk($sformatf("drop_hold%0d", i), 4'b0001, 2'd0, 1'b0);
    end
    req_i = 4'b0000;
    tick(); chk("drop_rel", 4'b0000, 2'd0, 1'b0);
    req_i = 4'b0011;                             // ptr 1 picks 1, ptr 0 would pick 0
    tick(); chk("drop_ptr1", 4'b0010, 2'd1, 1'b0);

    // Non-owner done and non-owner requests are ignored.
    done_i = 4'b1101;
    tick(); chk("nonowner_done", 4'b0010, 2'd1, 1'b0);
    done_i = 4'b0000;
    req_i  = 4'b0100;                            // owner 1 drops: release, ptr 2
    tick(); chk("drop1_rel", 4'b0000, 2'd0, 1'b0);
    tick(); chk("grant2", 4'b0100, 2'd2, 1'b0);

    // Reset mid-grant clears everything; pointer restarts at 0.
    reset = 1'b1;
    tick(); chk("rst_mid", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    req_i = 4'b1100;
    tick(); chk("rst_first", 4'b0100, 2'd2, 1'b0);
    req_i = 4'b1000;                             // owner 2 drops: ptr becomes 3
    tick(); chk("rst_rel", 4'b0000, 2'd0, 1'b0);
    reset = 1'b1;
    tick(); chk("rst_idle", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;
    req_i = 4'b1001;                             // ptr 0 picks 0, a stale ptr 3 would pick 3
    tick(); chk("rst_ptr0", 4'b0001, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
